// File: rtl/error_scoreboard_if.sv
// Bundle of comparison inputs, FIFO read port and verdict outputs for error_scoreboard.
// The master side is the test environment; the slave side is the scoreboard.
interface error_scoreboard_if #(
    parameter int DATAWIDTH = 32,
    parameter int TSW       = 32
);
    // meas/refv carry two's-complement words; they are only stored, never compared here
    logic [DATAWIDTH-1:0] meas;
    logic [DATAWIDTH-1:0] refv;
    logic                 valid;
    logic                 err;
    logic                 done;
    logic                 rd_en;
    logic [DATAWIDTH-1:0] rd_meas;
    logic [DATAWIDTH-1:0] rd_ref;
    logic [TSW-1:0]       rd_ts;
    logic                 empty;
    logic                 full;
    logic                 overflow;
    logic [TSW-1:0]       n_samples;
    logic [TSW-1:0]       n_errors;
    logic                 finished;
    logic                 pass;

    modport master (
        output meas, refv, valid, err, done, rd_en,
        input  rd_meas, rd_ref, rd_ts, empty, full, overflow,
        input  n_samples, n_errors, finished, pass
    );

    modport slave (
        input  meas, refv, valid, err, done, rd_en,
        output rd_meas, rd_ref, rd_ts, empty, full, overflow,
        output n_samples, n_errors, finished, pass
    );
endinterface

// File: rtl/error_scoreboard.sv
// Records mismatching meas/refv pairs with a cycle timestamp in a FWFT FIFO,
// keeps saturating sample/error counts and produces a pass/fail verdict at end of test.
module error_scoreboard #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int TSW       = 32
) (
    input logic               Clk,
    input logic               Rst,
    error_scoreboard_if.slave sb
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [TSW-1:0] TS_MAX   = {TSW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic                 active_s;
    logic                 in_done_s;

    logic [TSW-1:0]       cyc_q;
    logic [TSW-1:0]       nsamp_q;
    logic [TSW-1:0]       nsamp_d;
    logic [TSW-1:0]       nerr_q;
    logic [TSW-1:0]       nerr_d;

    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [DATAWIDTH-1:0] mem_meas_q [DEPTH];
    logic [DATAWIDTH-1:0] mem_ref_q  [DEPTH];
    logic [TSW-1:0]       mem_ts_q   [DEPTH];

    logic [DATAWIDTH-1:0] rd_meas_q;
    logic [DATAWIDTH-1:0] rd_meas_d;
    logic [DATAWIDTH-1:0] rd_ref_q;
    logic [DATAWIDTH-1:0] rd_ref_d;
    logic [TSW-1:0]       rd_ts_q;
    logic [TSW-1:0]       rd_ts_d;
    logic                 empty_q;
    logic                 full_q;
    logic                 ovf_q;
    logic                 finished_q;
    logic                 pass_q;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 wr_s;
    logic                 ovf_set_s;

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DONE is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sb.done) begin
                    state_d = DONE;
                end else if (sb.valid) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (sb.done) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: collection is live in IDLE and RUN, frozen in DONE
    always_comb begin
        active_s  = 1'b0;
        in_done_s = 1'b0;
        case (state_q)
            IDLE:    active_s  = 1'b1;
            RUN:     active_s  = 1'b1;
            DONE:    in_done_s = 1'b1;
            default: begin
                active_s  = 1'b0;
                in_done_s = 1'b0;
            end
        endcase
    end

    assign fifo_empty_s = (cnt_q == {CW{1'b0}});
    assign fifo_full_s  = (cnt_q == CNT_FULL);
    assign push_s       = active_s & sb.valid & sb.err;
    assign pop_s        = sb.rd_en & ~fifo_empty_s;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign wr_s         = push_s & (~fifo_full_s | pop_s);
    assign ovf_set_s    = push_s & fifo_full_s & ~pop_s;

    // FIFO occupancy next state
    always_comb begin
        case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Saturating sample and error counters
    always_comb begin
        nsamp_d = nsamp_q;
        nerr_d  = nerr_q;
        if (active_s && sb.valid) begin
            if (nsamp_q != TS_MAX) begin
                nsamp_d = nsamp_q + TSW'(1);
            end else begin
                nsamp_d = nsamp_q;
            end
            if (sb.err && (nerr_q != TS_MAX)) begin
                nerr_d = nerr_q + TSW'(1);
            end else begin
                nerr_d = nerr_q;
            end
        end else begin
            nsamp_d = nsamp_q;
            nerr_d  = nerr_q;
        end
    end

    // Next head entry; the outputs hold their last value once the FIFO drains
    always_comb begin
        rd_meas_d = rd_meas_q;
        rd_ref_d  = rd_ref_q;
        rd_ts_d   = rd_ts_q;
        if (pop_s && (cnt_d != {CW{1'b0}})) begin
            if (cnt_q > CW'(1)) begin
                rd_meas_d = mem_meas_q[rd_ptr_q + AW'(1)];
                rd_ref_d  = mem_ref_q[rd_ptr_q + AW'(1)];
                rd_ts_d   = mem_ts_q[rd_ptr_q + AW'(1)];
            end else begin
                rd_meas_d = sb.meas;
                rd_ref_d  = sb.refv;
                rd_ts_d   = cyc_q;
            end
        end else if (fifo_empty_s && wr_s) begin
            rd_meas_d = sb.meas;
            rd_ref_d  = sb.refv;
            rd_ts_d   = cyc_q;
        end else begin
            rd_meas_d = rd_meas_q;
            rd_ref_d  = rd_ref_q;
            rd_ts_d   = rd_ts_q;
        end
    end

    // FIFO storage, written at the tail
    always_ff @(posedge Clk) begin
        if (wr_s) begin
            mem_meas_q[wr_ptr_q] <= sb.meas;
            mem_ref_q[wr_ptr_q]  <= sb.refv;
            mem_ts_q[wr_ptr_q]   <= cyc_q;
        end
    end

    // Counters, pointers, status flags and verdict
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cyc_q      <= {TSW{1'b0}};
            nsamp_q    <= {TSW{1'b0}};
            nerr_q     <= {TSW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            rd_meas_q  <= {DATAWIDTH{1'b0}};
            rd_ref_q   <= {DATAWIDTH{1'b0}};
            rd_ts_q    <= {TSW{1'b0}};
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            finished_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            cyc_q      <= cyc_q + TSW'(1);
            nsamp_q    <= nsamp_d;
            nerr_q     <= nerr_d;
            cnt_q      <= cnt_d;
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            rd_meas_q  <= rd_meas_d;
            rd_ref_q   <= rd_ref_d;
            rd_ts_q    <= rd_ts_d;
            empty_q    <= (cnt_d == {CW{1'b0}});
            full_q     <= (cnt_d == CNT_FULL);
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end
            finished_q <= in_done_s;
            pass_q     <= in_done_s & (nerr_q == {TSW{1'b0}}) & ~ovf_q
                          & (nsamp_q != {TSW{1'b0}});
        end
    end

    assign sb.rd_meas   = rd_meas_q;
    assign sb.rd_ref    = rd_ref_q;
    assign sb.rd_ts     = rd_ts_q;
    assign sb.empty     = empty_q;
    assign sb.full      = full_q;
    assign sb.overflow  = ovf_q;
    assign sb.n_samples = nsamp_q;
    assign sb.n_errors  = nerr_q;
    assign sb.finished  = finished_q;
    assign sb.pass      = pass_q;

endmodule

// File: doc/error_scoreboard.md
ERROR_SCOREBOARD -- requirements
Module: error_scoreboard

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, width of compared data words.
REQ-002 SHALL have parameter DEPTH, default 8, mismatch FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TSW, default 32, timestamp/counter width.
REQ-004 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port meas  input  DATAWIDTH  measured DUT output (signed).
REQ-007 SHALL have port refv  input  DATAWIDTH  reference model output (signed).
REQ-008 SHALL have port valid  input  1  meas/refv comparison qualified this cycle.
REQ-009 SHALL have port err  input  1  mismatch flag from the upstream error monitor.
REQ-010 SHALL have port done  input  1  end-of-test strobe.
REQ-011 SHALL have port rd_en  input  1  pop head FIFO entry.
REQ-012 SHALL have ports rd_meas/rd_ref  output  DATAWIDTH each, rd_ts  output  TSW  head entry (first-word-fall-through).
REQ-013 SHALL have ports empty, full, overflow  output  1 each  FIFO status, overflow sticky.
REQ-014 SHALL have ports n_samples, n_errors  output  TSW each  saturating counters.
REQ-015 SHALL have ports finished, pass  output  1 each  final verdict.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on first cycle with valid=1; RUN->DONE on done=1; IDLE->DONE on done=1; DONE exits only via Rst.
REQ-017 SHALL increment a free-running cycle counter each cycle after reset deasserts, wrapping modulo 2^TSW; captured as timestamp.
REQ-018 SHALL, in IDLE or RUN, count n_samples +1 per cycle with valid=1, saturating at 2^TSW-1.
REQ-019 SHALL, in IDLE or RUN, count n_errors +1 per cycle with valid=1 and err=1, saturating at 2^TSW-1; err with valid=0 ignored.
REQ-020 SHALL push {meas, refv, cycle counter} into FIFO on valid=1 and err=1 (push visible one cycle later).
REQ-021 SHALL, on push while full and no pop, drop the entry and set overflow=1 (sticky until reset); n_errors still increments.
REQ-022 SHALL, on simultaneous push and pop when full, perform both; no overflow.
REQ-023 SHALL ignore rd_en when empty; simultaneous push/pop when empty pushes only.
REQ-024 SHALL present head entry on rd_* while empty=0; rd_* undefined-but-stable (hold last) when empty=1.
REQ-025 SHALL keep FIFO readable in DONE; pushes and counter updates disabled in DONE; valid/err/done ignored there.
REQ-026 SHALL assert finished=1 the cycle after entering DONE; pass=1 iff finished and n_errors=0 and overflow=0 and n_samples>0.
REQ-027 SHALL wrap FIFO pointers modulo DEPTH with a separate occupancy count of 0..DEPTH.

Reset
REQ-028 SHALL, while Rst=1, force state IDLE, cycle counter 0, n_samples 0, n_errors 0, FIFO empty (empty=1, full=0), overflow 0, finished 0, pass 0, rd_* 0.
REQ-029 SHALL, on reset asserted mid-operation, discard all FIFO contents and counts immediately without waiting for a clock edge.

Verification
REQ-030 SHALL cover: 20 cycles valid=1 err=0, then done -> n_samples=20, n_errors=0, empty=1, finished=1, pass=1.
REQ-031 SHALL cover: one error at cycle 5 after reset with meas=32'h0000_0007, refv=32'h0000_0005 -> empty=0, rd_meas=7, rd_ref=5, rd_ts=5; rd_en pulse -> empty=1; done -> pass=0.
REQ-032 SHALL cover: DEPTH=8, 10 consecutive errors no reads -> full=1, overflow=1, n_errors=10, 8 entries drained in order with ascending timestamps.
REQ-033 SHALL cover: FIFO full, push and rd_en same cycle -> full stays 1, overflow stays 0, oldest entry removed.
REQ-034 SHALL cover: done with no prior valid -> finished=1, n_samples=0, pass=0.
REQ-035 SHALL cover: Rst pulsed asynchronously between edges with 3 entries queued -> empty=1, counters 0, overflow 0 before next clock edge.
